// File: rtl/elevator_seq.sv
// Two-floor elevator car sequencer.
// Button presses are turned into one-shot requests. A single state register
// plus a tick-driven down-counter time the travel and door phases. Requests
// for the far floor that arrive while the car is busy are latched in pend1/pend2.
//
// state        | meaning
// -------------+-------------------------------------------------
// IDLE         | parked at floor 1, doors closed
// FLOOR1       | at floor 1, doors open, counting down DOOR_SEC
// FLOOR2       | at floor 2; doors open while count!=0, parked when 0
// GOING_TO_1   | travelling down, counting down TRAVEL_SEC
// GOING_TO_2   | travelling up, counting down TRAVEL_SEC
module elevator_seq #(
  parameter int TRAVEL_SEC = 5,
  parameter int DOOR_SEC   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_call1,
  input  logic       btn_call2,
  output logic [2:0] state,
  output logic [2:0] counting_value,
  output logic       door_open,
  output logic       pend1,
  output logic       pend2
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLOOR1     = 3'd1,
    S_FLOOR2     = 3'd2,
    S_GOING_TO_1 = 3'd3,
    S_GOING_TO_2 = 3'd4
  } car_state_t;

  localparam logic [2:0] TRAVEL_CNT = 3'(TRAVEL_SEC);
  localparam logic [2:0] DOOR_CNT   = 3'(DOOR_SEC);

  car_state_t st, st_n;
  logic [2:0] cnt_n;
  logic       door_n, pend1_n, pend2_n;
  logic       btn1_q, btn2_q;
  logic       call1, call2;

  // Button history samples every clock, including while rst is held, so a
  // button that is still held when reset releases is seen as old and does
  // not produce a request.
  always_ff @(posedge clk) begin
    btn1_q <= btn_call1;
    btn2_q <= btn_call2;
  end

  assign call1 = btn_call1 & ~btn1_q;
  assign call2 = btn_call2 & ~btn2_q;
  assign state = st;

  // State, counter, door and pending-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= S_IDLE;
      counting_value <= 3'd0;
      door_open      <= 1'b0;
      pend1          <= 1'b0;
      pend2          <= 1'b0;
    end else begin
      st             <= st_n;
      counting_value <= cnt_n;
      door_open      <= door_n;
      pend1          <= pend1_n;
      pend2          <= pend2_n;
    end
  end

  // Next-state, next-count and request latching.
  always_comb begin
    st_n    = st;
    cnt_n   = counting_value;
    pend1_n = pend1;
    pend2_n = pend2;
    case (st)
      S_IDLE: begin
        if (call1) begin
          st_n  = S_FLOOR1;
          cnt_n = DOOR_CNT;
          if (call2) pend2_n = 1'b1;
        end else if (call2) begin
          st_n  = S_GOING_TO_2;
          cnt_n = TRAVEL_CNT;
        end
      end
      S_FLOOR1: begin
        if (counting_value == 3'd0) begin
          // Doors-closed at floor 1 is IDLE.
          st_n = S_IDLE;
        end else begin
          if (call2) pend2_n = 1'b1;
          if (call1) begin
            cnt_n = DOOR_CNT;
          end else if (tick) begin
            if (counting_value == 3'd1) begin
              if (pend2 | call2) begin
                st_n    = S_GOING_TO_2;
                cnt_n   = TRAVEL_CNT;
                pend2_n = 1'b0;
              end else begin
                st_n  = S_IDLE;
                cnt_n = 3'd0;
              end
            end else begin
              cnt_n = counting_value - 3'd1;
            end
          end
        end
      end
      S_FLOOR2: begin
        if (counting_value == 3'd0) begin
          if (call2) begin
            cnt_n = DOOR_CNT;
            if (call1) pend1_n = 1'b1;
          end else if (call1) begin
            st_n  = S_GOING_TO_1;
            cnt_n = TRAVEL_CNT;
          end
        end else begin
          if (call1) pend1_n = 1'b1;
          if (call2) begin
            cnt_n = DOOR_CNT;
          end else if (tick) begin
            if (counting_value == 3'd1) begin
              if (pend1 | call1) begin
                st_n    = S_GOING_TO_1;
                cnt_n   = TRAVEL_CNT;
                pend1_n = 1'b0;
              end else begin
                cnt_n = 3'd0;
              end
            end else begin
              cnt_n = counting_value - 3'd1;
            end
          end
        end
      end
      S_GOING_TO_2: begin
        if (call1) pend1_n = 1'b1;
        if (tick && counting_value != 3'd0) begin
          if (counting_value == 3'd1) begin
            st_n    = S_FLOOR2;
            cnt_n   = DOOR_CNT;
            pend2_n = 1'b0;
          end else begin
            cnt_n = counting_value - 3'd1;
          end
        end
      end
      S_GOING_TO_1: begin
        if (call2) pend2_n = 1'b1;
        if (tick && counting_value != 3'd0) begin
          if (counting_value == 3'd1) begin
            st_n    = S_FLOOR1;
            cnt_n   = DOOR_CNT;
            pend1_n = 1'b0;
          end else begin
            cnt_n = counting_value - 3'd1;
          end
        end
      end
      default: begin
        st_n    = S_IDLE;
        cnt_n   = 3'd0;
        pend1_n = 1'b0;
        pend2_n = 1'b0;
      end
    endcase
    door_n = ((st_n == S_FLOOR1) || (st_n == S_FLOOR2)) && (cnt_n != 3'd0);
  end

endmodule

// File: tb/tb_elevator_seq.sv
// Testbench for elevator_seq: directed scenarios followed by random button,
// tick and reset traffic, all compared every cycle with a floor/phase model.
module tb_elevator_seq;

  localparam int TRAVEL = 5;
  localparam int DOOR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_call1 = 1'b0;
  logic       btn_call2 = 1'b0;
  logic [2:0] state;
  logic [2:0] counting_value;
  logic       door_open;
  logic       pend1;
  logic       pend2;

  int errors = 0;
  int checks = 0;

  // Reference model: which floor the car is at (or heading to), whether it is
  // moving, ticks remaining in the current phase, pending requests per floor.
  int m_loc;
  bit m_moving;
  int m_rem;
  bit m_p [1:2];
  bit m_prev [1:2];

  elevator_seq #(.TRAVEL_SEC(TRAVEL), .DOOR_SEC(DOOR)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_call1(btn_call1), .btn_call2(btn_call2),
    .state(state), .counting_value(counting_value), .door_open(door_open),
    .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loc = 1; m_moving = 1'b0; m_rem = 0; m_p[1] = 1'b0; m_p[2] = 1'b0;
  endtask

  function automatic int exp_state();
    if (m_moving) return (m_loc == 2) ? 4 : 3;
    if (m_loc == 1) return (m_rem > 0) ? 1 : 0;
    return 2;
  endfunction

  task automatic model_step(input bit r1, input bit r2, input bit t);
    bit r [1:2];
    int f, o;
    r[1] = r1; r[2] = r2;
    f = m_loc; o = 3 - m_loc;
    if (!m_moving) begin
      if (m_rem == 0) begin
        if (r[f]) begin
          m_rem = DOOR;
          if (r[o]) m_p[o] = 1'b1;
        end else if (r[o]) begin
          m_moving = 1'b1; m_loc = o; m_rem = TRAVEL;
        end
      end else begin
        if (r[o]) m_p[o] = 1'b1;
        if (r[f]) m_rem = DOOR;
        else if (t) begin
          m_rem--;
          if (m_rem == 0 && m_p[o]) begin
            m_p[o] = 1'b0; m_moving = 1'b1; m_loc = o; m_rem = TRAVEL;
          end
        end
      end
    end else begin
      if (r[o]) m_p[o] = 1'b1;
      if (t) begin
        m_rem--;
        if (m_rem == 0) begin
          m_moving = 1'b0; m_rem = DOOR; m_p[f] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), exp_state());
    chk("count", 32'(counting_value), m_rem);
    chk("door_open", 32'(door_open), 32'(!m_moving && m_rem > 0));
    chk("pend1", 32'(pend1), 32'(m_p[1]));
    chk("pend2", 32'(pend2), 32'(m_p[2]));
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare just after it.
  task automatic cyc(input bit r, input bit b1, input bit b2, input bit t);
    bit e1, e2;
    @(negedge clk);
    rst = r; btn_call1 = b1; btn_call2 = b2; tick = t;
    @(posedge clk);
    e1 = b1 && !m_prev[1];
    e2 = b2 && !m_prev[2];
    m_prev[1] = b1; m_prev[2] = b2;
    if (r) model_reset();
    else model_step(e1, e2, t);
    #1 check_all();
  endtask

  initial begin
    bit b1, b2, t, r;
    model_reset();
    m_prev[1] = 1'b0; m_prev[2] = 1'b0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(counting_value), 0);

    // Up-trip from IDLE, door timing at floor 2, park.
    cyc(0, 0, 1, 0);
    chk("go2_start", 32'(state), 4);
    chk("go2_count", 32'(counting_value), 5);
    repeat (5) cyc(0, 0, 0, 1);
    chk("arr2_state", 32'(state), 2);
    chk("arr2_count", 32'(counting_value), 3);
    chk("arr2_door", 32'(door_open), 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("park2_count", 32'(counting_value), 0);
    chk("park2_door", 32'(door_open), 0);
    repeat (2) cyc(0, 0, 0, 1);

    // Down-trip with a call2 latched mid-travel.
    cyc(0, 1, 0, 0);
    chk("go1_start", 32'(state), 3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    chk("pend2_set", 32'(pend2), 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("arr1_state", 32'(state), 1);
    chk("arr1_count", 32'(counting_value), 3);
    repeat (3) cyc(0, 0, 0, 1);
    chk("redepart_state", 32'(state), 4);
    chk("redepart_count", 32'(counting_value), 5);
    chk("redepart_pend2", 32'(pend2), 0);
    repeat (8) cyc(0, 0, 0, 1);

    // Reload wins over a tick at count=1.
    cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);
    chk("f1_at1", 32'(counting_value), 1);
    cyc(0, 1, 0, 1);
    chk("reload_state", 32'(state), 1);
    chk("reload_count", 32'(counting_value), 3);
    repeat (3) cyc(0, 0, 0, 1);
    chk("back_idle", 32'(state), 0);
    repeat (2) cyc(0, 0, 0, 1);

    // Simultaneous calls from IDLE.
    cyc(0, 1, 1, 0);
    chk("both_state", 32'(state), 1);
    chk("both_pend2", 32'(pend2), 1);
    cyc(1, 0, 0, 0);

    // Held call2 gives one request; async reset mid-travel; held at release.
    repeat (20) cyc(0, 0, 1, 0);
    chk("held_count", 32'(counting_value), 5);
    repeat (2) cyc(0, 0, 1, 1);
    chk("mid_count", 32'(counting_value), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_count", 32'(counting_value), 0);
    model_reset();
    repeat (2) cyc(1, 0, 1, 0);
    repeat (5) cyc(0, 0, 1, 1);
    chk("post_rst_state", 32'(state), 0);
    cyc(0, 0, 0, 0);

    // Random traffic.
    b1 = 1'b0; b2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) b1 = ~b1;
      if ($urandom_range(3) == 0) b2 = ~b2;
      t = ($urandom_range(2) == 0);
      r = ($urandom_range(199) == 0);
      cyc(r, b1, b2, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_seq.md
ELEVATOR_SEQ -- requirements
Module: elevator_seq

Interface
REQ-001 Parameter TRAVEL_SEC, default 5, travel time in ticks (legal 1..7).
REQ-002 Parameter DOOR_SEC, default 3, door-open time in ticks (legal 1..7).
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle time-base enable (1 Hz strobe); counts advance only when tick=1.
REQ-006 btn_call1  input  1  floor-1 call button, synchronized level.
REQ-007 btn_call2  input  1  floor-2 call button, synchronized level.
REQ-008 state  output  3  registered car state: 0 IDLE, 1 FLOOR1, 2 FLOOR2, 3 GOING_TO_1, 4 GOING_TO_2; drives the display controller.
REQ-009 counting_value  output  3  registered remaining ticks of the current travel or door phase; 0 when no phase is running.
REQ-010 door_open  output  1  registered; 1 when state is FLOOR1 or FLOOR2 and counting_value!=0.
REQ-011 pend1 / pend2  output  1 each  registered latched requests not yet served.

Function
REQ-012 Each button SHALL be rising-edge detected internally; one request per press; a held level produces no further requests.
REQ-013 IDLE = parked at floor 1, doors closed; FLOOR2 with counting_value=0 = parked at floor 2, doors closed.
REQ-014 IDLE: call1 -> FLOOR1, count=DOOR_SEC; call2 -> GOING_TO_2, count=TRAVEL_SEC.
REQ-015 IDLE, call1 and call2 in the same cycle: -> FLOOR1, count=DOOR_SEC, pend2 set.
REQ-016 FLOOR1 (door open): tick decrements count; a tick at count=1 -> count=0 and, in the same cycle, GOING_TO_2 with count=TRAVEL_SEC if pend2 is set (pend2 cleared), else IDLE.
REQ-017 FLOOR1: call1 reloads count=DOOR_SEC; a reload in the same cycle as a tick wins, with no decrement; call2 sets pend2.
REQ-018 FLOOR2 door open: same as FLOOR1 with the floors swapped; on expiry -> GOING_TO_1, count=TRAVEL_SEC if pend1 is set (pend1 cleared), else remain FLOOR2 with count=0.
REQ-019 FLOOR2 parked (count=0): call2 -> count=DOOR_SEC (reopen); call1 -> GOING_TO_1, count=TRAVEL_SEC; both at once -> reopen and set pend1.
REQ-020 GOING_TO_2: tick decrements count; a tick at count=1 -> FLOOR2, count=DOOR_SEC, pend2 cleared; call2 ignored; call1 sets pend1.
REQ-021 GOING_TO_1: mirror of REQ-020 (-> FLOOR1, count=DOOR_SEC, pend1 cleared; call1 ignored; call2 sets pend2).
REQ-022 count SHALL never wrap below 0 and never exceed the loaded parameter; a tick at count=0 has no effect.
REQ-023 All outputs change only on posedge clk; a button edge or tick affects the outputs on the next edge (1-cycle latency).
REQ-024 An illegal state encoding SHALL return to IDLE, count=0, pends cleared, on the next clock.

Reset
REQ-025 rst=1 SHALL immediately force: state=IDLE, counting_value=0, door_open=0, pend1=pend2=0, edge detectors = current button level treated as already seen.
REQ-026 Reset mid-travel or mid-door SHALL abandon the operation with no resumption; a button still held at release SHALL NOT generate a request.

Verification
REQ-027 Reset, press call2, 5 ticks -> GOING_TO_2 with counts 5,4,3,2,1, then FLOOR2 count=3, door_open=1; 3 more ticks -> FLOOR2 count=0, door_open=0.
REQ-028 From FLOOR2 parked, press call1 -> GOING_TO_1 count=5; press call2 mid-travel -> pend2=1; on arrival FLOOR1 count=3; after 3 ticks -> GOING_TO_2 count=5, pend2=0.
REQ-029 In FLOOR1 at count=1, press call1 in the same cycle as a tick -> count=3, state stays FLOOR1.
REQ-030 IDLE, call1 and call2 asserted in the same cycle -> FLOOR1 count=3, pend2=1.
REQ-031 Hold call2 high across 20 cycles with no ticks -> exactly one request; assert rst mid-GOING_TO_2 at count=3 -> IDLE, count=0 asynchronously; call2 still held at release -> no new request.
REQ-032 Tick while parked in IDLE or in FLOOR2 with count=0 -> no output change.
